// File: rtl/lc3b_types.sv
// ============================================================================
// lc3b_types : shared LC-3b datapath types and cache-arbiter enums
// Revision   : 1.0
// ============================================================================
`default_nettype none

package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_burst;

    typedef enum logic [1:0] {
        arb_idle    = 2'd0,
        arb_serve_i = 2'd1,
        arb_serve_d = 2'd2
    } lc3b_arb_state;

    typedef enum logic {
        req_icache = 1'b0,
        req_dcache = 1'b1
    } lc3b_requester;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
// cache_arbiter : shares the physical-memory burst port between I- and D-cache
// Revision      : 1.0
// ============================================================================
`default_nettype none

module cache_arbiter
    import lc3b_types::*;
#(
    parameter int DCACHE_PRIORITY = 0
) (
    input  logic      clk,
    input  logic      rst_n,

    input  logic      icache_read,
    input  logic      icache_write,
    input  lc3b_word  icache_address,
    input  lc3b_burst icache_wdata,
    output logic      icache_resp,
    output lc3b_burst icache_rdata,

    input  logic      dcache_read,
    input  logic      dcache_write,
    input  lc3b_word  dcache_address,
    input  lc3b_burst dcache_wdata,
    output logic      dcache_resp,
    output lc3b_burst dcache_rdata,

    output logic      pmem_read,
    output logic      pmem_write,
    output lc3b_word  pmem_address,
    output lc3b_burst pmem_wdata,
    input  logic      pmem_resp,
    input  lc3b_burst pmem_rdata
);

    lc3b_arb_state r_state;
    lc3b_arb_state w_next_state;
    lc3b_requester r_last_grant;
    lc3b_requester w_next_last_grant;
    lc3b_word      r_address;
    lc3b_word      w_next_address;
    lc3b_burst     r_wdata;
    lc3b_burst     w_next_wdata;
    logic          r_write;
    logic          w_next_write;

    logic          w_i_pend;
    logic          w_d_pend;
    logic          w_grant_d;
    logic          w_serving;

    assign w_i_pend = icache_read | icache_write;
    assign w_d_pend = dcache_read | dcache_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= arb_idle;
            r_last_grant <= req_icache;
            r_address    <= '0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_last_grant <= w_next_last_grant;
            r_address    <= w_next_address;
            r_wdata      <= w_next_wdata;
            r_write      <= w_next_write;
        end
    end

    // On a tie, round-robin hands the port to whichever cache was not served last.
    always_comb begin
        w_grant_d = 1'b0;
        if (w_d_pend && !w_i_pend) begin
            w_grant_d = 1'b1;
        end else if (w_d_pend && w_i_pend) begin
            w_grant_d = (DCACHE_PRIORITY != 0) || (r_last_grant == req_icache);
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_last_grant = r_last_grant;
        w_next_address    = r_address;
        w_next_wdata      = r_wdata;
        w_next_write      = r_write;
        case (r_state)
            arb_idle: begin
                if (w_grant_d) begin
                    w_next_state      = arb_serve_d;
                    w_next_last_grant = req_dcache;
                    w_next_address    = dcache_address;
                    w_next_wdata      = dcache_wdata;
                    w_next_write      = dcache_write;
                end else if (w_i_pend) begin
                    w_next_state      = arb_serve_i;
                    w_next_last_grant = req_icache;
                    w_next_address    = icache_address;
                    w_next_wdata      = icache_wdata;
                    w_next_write      = icache_write;
                end
            end
            arb_serve_i, arb_serve_d: begin
                if (pmem_resp) begin
                    w_next_state = arb_idle;
                end
            end
            default: w_next_state = arb_idle;
        endcase
    end

    assign w_serving = (r_state == arb_serve_i) || (r_state == arb_serve_d);

    always_comb begin
        pmem_read    = w_serving && !r_write;
        pmem_write   = w_serving && r_write;
        pmem_address = r_address;
        pmem_wdata   = r_wdata;
        icache_resp  = (r_state == arb_serve_i) && pmem_resp;
        dcache_resp  = (r_state == arb_serve_d) && pmem_resp;
        icache_rdata = pmem_rdata;
        dcache_rdata = pmem_rdata;
    end

endmodule

`default_nettype wire
